ysyx_040066_clint_mh: RTL and testbench

Parametrised successor of the core-local timer: a memory-mapped CLINT serving HARTS harts, with one mtime, per-hart mtimecmp/msip, and a programmable tick prescaler. It sits beside the M stage. It decodes the M-stage address and intercepts accesses that fall in its window. Non-hit accesses are forwarded to the data bus. It drives per-hart timer and software interrupt lines to the CSR unit.

---
 rtl/ysyx_040066_clint_mh.sv | 139 +++++++++++++
 tb/tb_ysyx_040066_clint_mh.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_040066_clint_mh.sv
// Core-local interruptor for HARTS harts: one free-running mtime with a tick prescaler,
// per-hart mtimecmp/msip, intercepting M-stage accesses that fall inside its 64 KiB window.
module ysyx_040066_clint_mh #(
  parameter int          HARTS    = 2,
  parameter logic [63:0] BASE     = 64'h0000_0000_0200_0000,
  parameter int          TICK_DIV = 1,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      addr,
  input  logic [63:0]      wdata,
  input  logic [7:0]       wmask,
  input  logic             MemRd,
  input  logic             MemWr,
  output logic             MemRd_real,
  output logic             MemWr_real,
  output logic             hit,
  output logic             rd_valid,
  output logic [63:0]      rdata,
  output logic             error,
  output logic [HARTS-1:0] timer_intr,
  output logic [HARTS-1:0] soft_intr
);

  localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [12:0]      MTIME_DW   = 13'h17FF;  // 0xBFF8 >> 3
  localparam logic [12:0]      MTCMP_DW0  = 13'h0800;  // 0x4000 >> 3

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      mtime_q, mtime_d;
  logic [63:0]      mtimecmp_q [HARTS];
  logic [63:0]      mtimecmp_d [HARTS];
  logic [HARTS-1:0] msip_q, msip_d;
  logic             rd_valid_q, rd_valid_d;
  logic             error_q, error_d;
  logic [63:0]      rdata_q, rdata_d;
  logic [HARTS-1:0] timer_q, timer_d;
  logic [HARTS-1:0] soft_q, soft_d;

  logic [HARTS-1:0] msip_sel, cmp_sel;
  logic             mtime_sel, mapped, msip_bad, acc, wr_ok, rd_ok, tick;
  logic [63:0]      mtime_inc, rd_val;

  function automatic logic [63:0] merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                        input logic [7:0] mask);
    logic [63:0] r;
    r = old_v;
    for (int b = 0; b < 8; b++) begin
      if (mask[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

  always_comb begin
    hit       = (addr[63:16] == BASE[63:16]);
    acc       = hit && (MemRd || MemWr);
    mtime_sel = (addr[15:3] == MTIME_DW);
    msip_sel  = '0;
    cmp_sel   = '0;
    for (int h = 0; h < HARTS; h++) begin
      msip_sel[h] = (addr[15:2] == 14'(h));
      cmp_sel[h]  = (addr[15:3] == MTCMP_DW0 + 13'(h));
    end
    mapped = (|msip_sel) || (|cmp_sel) || mtime_sel;
    // an msip word may only be touched through the lanes of its own half
    msip_bad = (addr[1:0] != 2'b00) || (addr[2] ? (|wmask[3:0]) : (|wmask[7:4]));
    error_d  = acc && (!mapped || (MemRd && MemWr)
                       || ((mtime_sel || (|cmp_sel)) && (addr[2:0] != 3'b000))
                       || ((|msip_sel) && msip_bad));
    wr_ok = acc && MemWr && !error_d;
    rd_ok = acc && MemRd && !error_d;

    rd_val = '0;
    if (mtime_sel) rd_val = mtime_q;
    for (int h = 0; h < HARTS; h++) begin
      if (cmp_sel[h]) rd_val = mtimecmp_q[h];
      if (msip_sel[h]) rd_val = addr[2] ? {31'b0, msip_q[h], 32'b0} : {63'b0, msip_q[h]};
    end

    tick      = (cnt_q == TICK_LAST);
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    mtime_inc = mtime_q + 64'(tick);
    mtime_d   = mtime_inc;
    if (wr_ok && mtime_sel) begin
      mtime_d = merge(mtime_inc, wdata, wmask);
      cnt_d   = '0;
    end

    msip_d = msip_q;
    for (int h = 0; h < HARTS; h++) begin
      mtimecmp_d[h] = mtimecmp_q[h];
      if (wr_ok && cmp_sel[h]) mtimecmp_d[h] = merge(mtimecmp_q[h], wdata, wmask);
      if (wr_ok && msip_sel[h] && (addr[2] ? wmask[4] : wmask[0]))
        msip_d[h] = addr[2] ? wdata[32] : wdata[0];
    end

    // interrupt lines follow the state as it will be after this edge
    for (int h = 0; h < HARTS; h++) begin
      timer_d[h] = (mtime_d >= mtimecmp_d[h]);
    end
    soft_d     = msip_d;
    rd_valid_d = acc;
    rdata_d    = rd_ok ? rd_val : 64'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      mtime_q    <= '0;
      msip_q     <= '0;
      rd_valid_q <= 1'b0;
      error_q    <= 1'b0;
      rdata_q    <= '0;
      timer_q    <= '0;
      soft_q     <= '0;
      for (int h = 0; h < HARTS; h++) mtimecmp_q[h] <= '1;
    end else begin
      cnt_q      <= cnt_d;
      mtime_q    <= mtime_d;
      msip_q     <= msip_d;
      rd_valid_q <= rd_valid_d;
      error_q    <= error_d;
      rdata_q    <= rdata_d;
      timer_q    <= timer_d;
      soft_q     <= soft_d;
      for (int h = 0; h < HARTS; h++) mtimecmp_q[h] <= mtimecmp_d[h];
    end
  end

  assign MemRd_real = MemRd && !hit;
  assign MemWr_real = MemWr && !hit;
  assign rd_valid   = rd_valid_q;
  assign rdata      = rdata_q;
  assign error      = error_q;
  assign timer_intr = timer_q;
  assign soft_intr  = soft_q;

endmodule

// File: tb/tb_ysyx_040066_clint_mh.sv
// Directed bench for the CLINT: one instance ticking every cycle, one with a divide-by-4
// prescaler, both driven by the same access stream.
module tb_ysyx_040066_clint_mh;

  localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MTIME = BASE + 64'hBFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] addr = '0, wdata = '0;
  logic [7:0]  wmask = '0;
  logic        MemRd = 1'b0, MemWr = 1'b0;

  logic        mrr1, mwr1, hit1, rv1, er1, mrr4, mwr4, hit4, rv4, er4;
  logic [63:0] rd1, rd4;
  logic [1:0]  ti1, si1, ti4, si4;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic        s_hit, s_mrr, s_mwr, s_rv, s_er, s_rv4;
  logic [63:0] s_rd, s_rd4;

  ysyx_040066_clint_mh #(.HARTS(2), .BASE(BASE), .TICK_DIV(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wmask(wmask), .MemRd(MemRd),
    .MemWr(MemWr), .MemRd_real(mrr1), .MemWr_real(mwr1), .hit(hit1), .rd_valid(rv1),
    .rdata(rd1), .error(er1), .timer_intr(ti1), .soft_intr(si1));

  ysyx_040066_clint_mh #(.HARTS(2), .BASE(BASE), .TICK_DIV(4), .CNT_W(16)) u_dut4 (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wmask(wmask), .MemRd(MemRd),
    .MemWr(MemWr), .MemRd_real(mrr4), .MemWr_real(mwr4), .hit(hit4), .rd_valid(rv4),
    .rdata(rd4), .error(er4), .timer_intr(ti4), .soft_intr(si4));

  always #5 clk = ~clk;

  // number of rising edges since reset release; equals mtime of the divide-by-1 instance
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic acc(input logic r, input logic w, input logic [63:0] a,
                     input logic [63:0] d, input logic [7:0] m);
    MemRd = r; MemWr = w; addr = a; wdata = d; wmask = m;
    #1;
    s_hit = hit1; s_mrr = mrr1; s_mwr = mwr1;
    @(posedge clk);
    #1;
    s_rv = rv1; s_rd = rd1; s_er = er1; s_rv4 = rv4; s_rd4 = rd4;
    MemRd = 1'b0; MemWr = 1'b0;
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [63:0] a;
    logic [63:0] d;
    logic [7:0]  m;
    logic        e_hit;
    logic        e_rv;
    logic        e_er;
    logic [63:0] e_rd;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int k;
    logic [63:0] w0;

    tbl[0]  = '{1'b1, 1'b0, BASE + 64'h4000,  64'h0, 8'hFF, 1'b1, 1'b1, 1'b0, ONES};
    tbl[1]  = '{1'b1, 1'b0, BASE + 64'h4008,  64'h0, 8'hFF, 1'b1, 1'b1, 1'b0, ONES};
    tbl[2]  = '{1'b1, 1'b0, BASE + 64'h0000,  64'h0, 8'h0F, 1'b1, 1'b1, 1'b0, 64'h0};
    tbl[3]  = '{1'b1, 1'b0, BASE + 64'h8000,  64'h0, 8'hFF, 1'b1, 1'b1, 1'b1, 64'h0};
    tbl[4]  = '{1'b1, 1'b0, BASE + 64'h0008,  64'h0, 8'h0F, 1'b1, 1'b1, 1'b1, 64'h0};
    tbl[5]  = '{1'b1, 1'b0, BASE + 64'h4010,  64'h0, 8'hFF, 1'b1, 1'b1, 1'b1, 64'h0};
    tbl[6]  = '{1'b1, 1'b0, BASE + 64'hBFFC,  64'h0, 8'hF0, 1'b1, 1'b1, 1'b1, 64'h0};
    tbl[7]  = '{1'b0, 1'b1, BASE + 64'hBFFC,  ONES,  8'hF0, 1'b1, 1'b1, 1'b1, 64'h0};
    tbl[8]  = '{1'b0, 1'b1, BASE + 64'h4004,  64'h0, 8'hF0, 1'b1, 1'b1, 1'b1, 64'h0};
    tbl[9]  = '{1'b0, 1'b1, BASE + 64'h0000,  ONES,  8'hFF, 1'b1, 1'b1, 1'b1, 64'h0};
    tbl[10] = '{1'b1, 1'b1, BASE + 64'h4000,  64'h0, 8'hFF, 1'b1, 1'b1, 1'b1, 64'h0};
    tbl[11] = '{1'b1, 1'b0, BASE - 64'h8,     64'h0, 8'hFF, 1'b0, 1'b0, 1'b0, 64'h0};
    tbl[12] = '{1'b0, 1'b1, BASE + 64'h10000, 64'h0, 8'hFF, 1'b0, 1'b0, 1'b0, 64'h0};
    tbl[13] = '{1'b1, 1'b0, BASE + 64'h0002,  64'h0, 8'h0C, 1'b1, 1'b1, 1'b1, 64'h0};

    // reset state
    idle(2);
    chk("reset_rd_valid", 64'(rv1), 64'h0);
    chk("reset_error", 64'(er1), 64'h0);
    chk("reset_rdata", rd1, 64'h0);
    chk("reset_timer_intr", 64'(ti1), 64'h0);
    chk("reset_soft_intr", 64'(si1), 64'h0);

    // release after an edge: mtime (div 1) is n after the n-th edge, read returns n-1
    rst = 1'b0;
    idle(10);
    acc(1'b1, 1'b0, MTIME, 64'h0, 8'hFF);
    chk("idle_mtime_div1", s_rd, 64'd10);
    chk("idle_mtime_div4", s_rd4, 64'd2);
    chk("idle_timer_intr", 64'(ti1), 64'h0);

    for (int i = 0; i < 14; i++) begin
      acc(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].m);
      chk($sformatf("vec%0d_hit", i), 64'(s_hit), 64'(tbl[i].e_hit));
      chk($sformatf("vec%0d_MemRd_real", i), 64'(s_mrr), 64'(tbl[i].r && !tbl[i].e_hit));
      chk($sformatf("vec%0d_MemWr_real", i), 64'(s_mwr), 64'(tbl[i].w && !tbl[i].e_hit));
      chk($sformatf("vec%0d_rd_valid", i), 64'(s_rv), 64'(tbl[i].e_rv));
      chk($sformatf("vec%0d_error", i), 64'(s_er), 64'(tbl[i].e_er));
      chk($sformatf("vec%0d_rdata", i), s_rd, tbl[i].e_rd);
    end

    // erroring accesses must have left all state alone
    acc(1'b1, 1'b0, BASE + 64'h4000, 64'h0, 8'hFF);
    chk("post_err_mtimecmp0", s_rd, ONES);
    chk("post_err_soft_intr", 64'(si1), 64'h0);
    acc(1'b1, 1'b0, MTIME, 64'h0, 8'hFF);
    chk("post_err_mtime", s_rd, 64'(cyc - 1));

    // mtimecmp[1] = current mtime + 5: line must rise on the 4th edge after the write
    w0 = 64'(cyc);
    acc(1'b0, 1'b1, BASE + 64'h4008, w0 + 64'd5, 8'hFF);
    chk("cmp_write_no_intr", 64'(ti1), 64'h0);
    k = 0;
    while (!ti1[1] && k < 20) begin
      idle(1);
      k++;
    end
    chk("timer_rise_latency", 64'(k), 64'd4);
    chk("timer_intr0_quiet", 64'(ti1[0]), 64'h0);
    acc(1'b0, 1'b1, BASE + 64'h4008, ONES, 8'hFF);
    chk("timer_fall", 64'(ti1[1]), 64'h0);

    // msip[1] through the upper lanes
    acc(1'b0, 1'b1, BASE + 64'h4, 64'hFFFF_FFFF_0000_0000, 8'hF0);
    chk("msip1_soft_intr", 64'(si1), 64'h2);
    acc(1'b1, 1'b0, BASE + 64'h4, 64'h0, 8'hF0);
    chk("msip1_readback", s_rd, 64'h0000_0001_0000_0000);
    chk("msip1_read_error", 64'(s_er), 64'h0);

    // put the div-4 prescaler at count 1 so a missed restart would move the tick
    k = 0;
    while ((cyc % 4) != 1 && k < 8) begin
      idle(1);
      k++;
    end
    acc(1'b0, 1'b1, MTIME, 64'd100, 8'hFF);
    idle(3);
    acc(1'b1, 1'b0, MTIME, 64'h0, 8'hFF);
    chk("presc_read1_div4", s_rd4, 64'd100);
    chk("presc_read1_div1", s_rd, 64'd103);
    acc(1'b1, 1'b0, MTIME, 64'h0, 8'hFF);
    chk("presc_read2_div4", s_rd4, 64'd101);
    chk("presc_read2_div1", s_rd, 64'd104);
    idle(3);
    acc(1'b1, 1'b0, MTIME, 64'h0, 8'hFF);
    chk("presc_read3_div4", s_rd4, 64'd102);
    chk("presc_read3_div1", s_rd, 64'd108);

    // upper-lane write coinciding with a tick: lower lanes keep the incremented value
    acc(1'b0, 1'b1, MTIME, 64'h5555_5555_0000_0000, 8'hF0);
    acc(1'b1, 1'b0, MTIME, 64'h0, 8'hFF);
    chk("partial_mtime_write", s_rd, 64'h5555_5555_0000_006E);

    // reset in the middle of a read pulse
    acc(1'b0, 1'b1, BASE + 64'h4000, 64'h0, 8'hFF);
    chk("cmp0_zero_intr", 64'(ti1), 64'h1);
    acc(1'b1, 1'b0, MTIME, 64'h0, 8'hFF);
    chk("pre_reset_rd_valid", 64'(s_rv), 64'h1);
    MemRd = 1'b1; addr = MTIME;
    rst = 1'b1;
    #1;
    chk("async_rst_rd_valid", 64'(rv1), 64'h0);
    chk("async_rst_rdata", rd1, 64'h0);
    chk("async_rst_timer", 64'(ti1), 64'h0);
    chk("async_rst_soft", 64'(si1), 64'h0);
    @(posedge clk);
    #1;
    chk("rst_held_rd_valid", 64'(rv1), 64'h0);
    MemRd = 1'b0;
    rst = 1'b0;
    acc(1'b1, 1'b0, MTIME, 64'h0, 8'hFF);
    chk("post_rst_mtime", s_rd, 64'h0);
    chk("post_rst_mtime_div4", s_rd4, 64'h0);
    acc(1'b1, 1'b0, BASE + 64'h4000, 64'h0, 8'hFF);
    chk("post_rst_mtimecmp0", s_rd, ONES);
    acc(1'b1, 1'b0, BASE + 64'h4, 64'h0, 8'hF0);
    chk("post_rst_msip1", s_rd, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
